// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat table controller: deal states,
// draw thresholds and the rank-to-value mapping.
package baccarat_pkg;

   typedef enum logic [3:0] {
      DEAL_P1,
      DEAL_D1,
      DEAL_P2,
      DEAL_D2,
      DECIDE,
      DEAL_P3,
      BANKER,
      DEAL_D3,
      DONE
   } deal_state_t;

   localparam logic [3:0] NATURAL_MIN = 4'd8;
   localparam logic [3:0] DRAW_MAX    = 4'd5;

   // Load vector bit order follows deal order: P1, D1, P2, D2, P3, D3.
   localparam int LOAD_W = 6;

   function automatic logic [3:0] card_value(input logic [3:0] rank);
      return (rank >= 4'd10) ? 4'd0 : rank;
   endfunction

   function automatic logic [LOAD_W-1:0] load_vec(input deal_state_t s);
      logic [LOAD_W-1:0] v;
      v = '0;
      case (s)
         DEAL_P1: v[0] = 1'b1;
         DEAL_D1: v[1] = 1'b1;
         DEAL_P2: v[2] = 1'b1;
         DEAL_D2: v[3] = 1'b1;
         DEAL_P3: v[4] = 1'b1;
         DEAL_D3: v[5] = 1'b1;
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/baccarat_fsm_banker_draw_rule.sv
// Banker third-card rule once the player has drawn: decides from the banker
// score and the value (0-9) of the player's third card.
module banker_draw_rule
   import baccarat_pkg::*;
(
   input  logic [3:0] dscore_i,
   input  logic [3:0] value_i,
   output logic       draw_o
);

   always_comb begin
      draw_o = 1'b0;
      case (dscore_i)
         4'd0, 4'd1, 4'd2: draw_o = 1'b1;
         4'd3:             draw_o = (value_i != 4'd8);
         4'd4:             draw_o = (value_i >= 4'd2) && (value_i <= 4'd7);
         4'd5:             draw_o = (value_i >= 4'd4) && (value_i <= 4'd7);
         4'd6:             draw_o = (value_i >= 4'd6) && (value_i <= 4'd7);
         default:          draw_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat deal sequencer: one card load per slow clock edge, third-card
// rules for player and banker, and win lights once the hand is complete.
module baccarat_fsm
   import baccarat_pkg::*;
(
   input  logic        slow_clock,
   input  logic        reset,
   input  logic [3:0]  pscore,
   input  logic [3:0]  dscore,
   input  logic [3:0]  pcard3,
   output logic        load_pcard1,
   output logic        load_pcard2,
   output logic        load_pcard3,
   output logic        load_dcard1,
   output logic        load_dcard2,
   output logic        load_dcard3,
   output logic        player_win_light,
   output logic        dealer_win_light,
   output deal_state_t dbg_state_o
);

   deal_state_t       state_q, state_d;
   logic [LOAD_W-1:0] load_q;
   logic              banker_draw;

   banker_draw_rule u_banker_rule (
      .dscore_i (dscore),
      .value_i  (card_value(pcard3)),
      .draw_o   (banker_draw)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         DEAL_P1: state_d = DEAL_D1;
         DEAL_D1: state_d = DEAL_P2;
         DEAL_P2: state_d = DEAL_D2;
         DEAL_D2: state_d = DECIDE;
         DECIDE: begin
            if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN))
               state_d = DONE;
            else if (pscore <= DRAW_MAX)
               state_d = DEAL_P3;
            else if (dscore <= DRAW_MAX)
               state_d = DEAL_D3;
            else
               state_d = DONE;
         end
         DEAL_P3: state_d = BANKER;
         BANKER:  state_d = banker_draw ? DEAL_D3 : DONE;
         DEAL_D3: state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = DEAL_P1;
      endcase
   end

   // Loads are registered from the next state so each is a clean Moore output.
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state_q <= DEAL_P1;
         load_q  <= load_vec(DEAL_P1);
      end else begin
         state_q <= state_d;
         load_q  <= load_vec(state_d);
      end
   end

   assign load_pcard1 = load_q[0];
   assign load_dcard1 = load_q[1];
   assign load_pcard2 = load_q[2];
   assign load_dcard2 = load_q[3];
   assign load_pcard3 = load_q[4];
   assign load_dcard3 = load_q[5];
   assign dbg_state_o = state_q;

   // Lights follow the live scores in DONE; a tie lights both.
   always_comb begin
      player_win_light = 1'b0;
      dealer_win_light = 1'b0;
      if (state_q == DONE) begin
         player_win_light = (pscore >= dscore);
         dealer_win_light = (dscore >= pscore);
      end
   end

endmodule
